// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for decode: one-cycle latency, valid/ready with stall hold,
// flush drop, XLEN 32/64, CSR zimm and unsigned-I modes, and a saturating illegal-selector count.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      Imm,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    SRC_I  = 3'b000,
    SRC_S  = 3'b001,
    SRC_U  = 3'b010,
    SRC_Z  = 3'b011,
    SRC_IU = 3'b100,
    SRC_B  = 3'b101,
    SRC_J  = 3'b110,
    SRC_X  = 3'b111
  } imm_src_e;

  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_d, imm_q;
  logic [TAG_W-1:0]   tag_q;
  logic               err_d, err_q;
  logic               vld_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;

  // Every mode is first formed as a signed 32-bit value; widening the signed value
  // to XLEN then extends U from bit 31 and leaves zero-extended modes positive.
  always_comb begin
    imm32 = '0;
    err_d = 1'b0;
    case (imm_src_e'(ImmSrc))
      SRC_I:  imm32 = 32'($signed(Imm[24:13]));
      SRC_S:  imm32 = 32'($signed({Imm[24:18], Imm[4:0]}));
      SRC_B:  imm32 = 32'($signed({Imm[24], Imm[0], Imm[23:18], Imm[4:1], 1'b0}));
      SRC_U:  imm32 = {Imm[24:5], 12'b0};
      SRC_J:  imm32 = 32'($signed({Imm[24], Imm[12:5], Imm[13], Imm[23:14], 1'b0}));
      SRC_Z:  imm32 = {27'b0, Imm[12:8]};
      SRC_IU: imm32 = {20'b0, Imm[24:13]};
      default: begin
        imm32 = '0;
        err_d = 1'b1;
      end
    endcase
    imm_d = XLEN'(imm32);
  end

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      imm_q <= '0;
      tag_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      imm_q <= imm_d;
      tag_q <= in_tag;
      err_q <= err_d;
      if (err_d && !(&cnt_q)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign ImmExt    = imm_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit instance with a 2-bit error counter and a
// 64-bit instance sharing the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [24:0] Imm;
  logic [2:0]  ImmSrc;
  logic [4:0]  in_tag;

  logic        in_ready, out_valid, out_err;
  logic [31:0] ImmExt;
  logic [4:0]  out_tag;
  logic [1:0]  err_cnt;

  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] ImmExt64;
  logic [4:0]  out_tag64;
  logic [7:0]  err_cnt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .Imm(Imm), .ImmSrc(ImmSrc), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .ImmExt(ImmExt), .out_tag(out_tag), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .Imm(Imm), .ImmSrc(ImmSrc), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .ImmExt(ImmExt64), .out_tag(out_tag64), .out_err(out_err64),
    .err_cnt(err_cnt64)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [24:0] imm, input logic [2:0] src, input logic [4:0] tag);
    in_valid = 1'b1;
    Imm      = imm;
    ImmSrc   = src;
    in_tag   = tag;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(25'h1FFFFFF, 3'b111, 5'd9);
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (err_cnt !== 2'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    checks++;
    if (ImmExt !== 32'h0 || out_tag !== 5'd0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got imm=%h tag=%0d err=%b want 0/0/0", ImmExt, out_tag, out_err);
    end
    checks++;
    if (out_valid64 !== 1'b0 || ImmExt64 !== 64'h0) begin
      errors++;
      $display("FAIL reset_64 got vld=%b imm=%h want 0/0", out_valid64, ImmExt64);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_modes32();
    logic [24:0] vimm [7];
    logic [2:0]  vsrc [7];
    logic [31:0] vexp [7];
    vimm[0] = 25'h1FFFFFF;                      vsrc[0] = 3'b000; vexp[0] = 32'hFFFFFFFF;
    vimm[1] = 25'b1111111111110000000000000;    vsrc[1] = 3'b101; vexp[1] = 32'hFFFFF7E0;
    vimm[2] = 25'h001F00;                       vsrc[2] = 3'b010; vexp[2] = 32'h000F8000;
    vimm[3] = 25'h001F00;                       vsrc[3] = 3'b110; vexp[3] = 32'h000F8000;
    vimm[4] = 25'h001F00;                       vsrc[4] = 3'b011; vexp[4] = 32'h0000001F;
    vimm[5] = 25'h001F00;                       vsrc[5] = 3'b100; vexp[5] = 32'h00000000;
    vimm[6] = 25'h0040005;                      vsrc[6] = 3'b001; vexp[6] = 32'h00000025;
    for (int i = 0; i < 7; i++) begin
      drain();
      drive(vimm[i], vsrc[i], 5'(i + 1));
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || ImmExt !== vexp[i] || out_tag !== 5'(i + 1) || out_err !== 1'b0) begin
        errors++;
        $display("FAIL mode_%0d src=%b got vld=%b imm=%h tag=%0d err=%b want 1/%h/%0d/0",
                 i, vsrc[i], out_valid, ImmExt, out_tag, out_err, vexp[i], i + 1);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL consume_drop got %b want 0", out_valid); end
  endtask

  task automatic test_xlen64();
    drain();
    drive(25'h1000000, 3'b010, 5'd4);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid64 !== 1'b1 || ImmExt64 !== 64'hFFFFFFFF80000000) begin
      errors++;
      $display("FAIL xlen64_u got vld=%b imm=%h want 1/ffffffff80000000", out_valid64, ImmExt64);
    end
    drive(25'h001F00, 3'b011, 5'd5);
    step();
    in_valid = 1'b0;
    checks++;
    if (ImmExt64 !== 64'h000000000000001F) begin
      errors++;
      $display("FAIL xlen64_z got %h want 000000000000001f", ImmExt64);
    end
  endtask

  task automatic test_stall();
    drain();
    out_ready = 1'b0;
    drive(25'h0012000, 3'b000, 5'd3);
    step();
    drive(25'h1FFE000, 3'b100, 5'd7);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b1 || ImmExt !== 32'h9 || out_tag !== 5'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d got vld=%b imm=%h tag=%0d rdy=%b want 1/9/3/0",
                 c, out_valid, ImmExt, out_tag, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_rdy got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ImmExt !== 32'h00000FFF || out_tag !== 5'd7) begin
      errors++;
      $display("FAIL stall_next got vld=%b imm=%h tag=%0d want 1/00000fff/7", out_valid, ImmExt, out_tag);
    end
  endtask

  task automatic test_back_to_back();
    drain();
    for (int i = 0; i < 3; i++) begin
      drive(25'(i) << 13, 3'b000, 5'(10 + i));
      step();
      checks++;
      if (out_valid !== 1'b1 || ImmExt !== 32'(i) || out_tag !== 5'(10 + i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d got vld=%b imm=%h tag=%0d rdy=%b want 1/%0d/%0d/1",
                 i, out_valid, ImmExt, out_tag, in_ready, i, 10 + i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    drain();
    flush = 1'b1;
    drive(25'h1FFFFFF, 3'b111, 5'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL flush_incoming got vld=%b cnt=%0d want 0/0", out_valid, err_cnt);
    end
    out_ready = 1'b0;
    drive(25'h0002000, 3'b000, 5'd2);
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight got %b want 0", out_valid); end
    drive(25'h0002000, 3'b000, 5'd2);
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_stall got %b want 0", out_valid); end
  endtask

  task automatic test_illegal_sat();
    logic [1:0] exp_cnt;
    drain();
    for (int i = 0; i < 5; i++) begin
      drive(25'h1FFFFFF, 3'b111, 5'd6);
      step();
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || ImmExt !== 32'h0 || err_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL illegal_%0d got vld=%b err=%b imm=%h cnt=%0d want 1/1/0/%0d",
                 i, out_valid, out_err, ImmExt, err_cnt, exp_cnt);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (err_cnt64 !== 8'd5) begin errors++; $display("FAIL illegal_cnt64 got %0d want 5", err_cnt64); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Imm = '0; ImmSrc = '0; in_tag = '0;
    test_reset();
    test_modes32();
    test_xlen64();
    test_stall();
    test_back_to_back();
    test_flush();
    test_illegal_sat();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
